// File: rtl/flappy_pkg.sv
// Shared types and helpers for the Flappy Bird game sequencer.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int BCD_DIGITS = 3;

  typedef logic [4*BCD_DIGITS-1:0] bcd3_t;

  // Valid packed BCD orders the same way as the decimal value it encodes.
  function automatic logic bcd3_gt(input bcd3_t a, input bcd3_t b);
    return a > b;
  endfunction

  function automatic bcd3_t to_bcd3(input int v);
    bcd3_t r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear and saturation at MAX.
module bcd_counter3
  import flappy_pkg::*;
#(
  parameter bcd3_t MAX = 12'h999
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  inc,
  output bcd3_t count
);

  bcd3_t count_inc;

  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Frame-synchronous game sequencer: gates physics/scrolling, merges flaps
// to one per frame, detects game over and tracks current and best BCD score.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int DIE_FRAMES = 60,
  parameter int OVER_HOLD  = 30,
  parameter int SCORE_MAX  = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        flap_req,
  input  logic        hit,
  input  logic        bird_at_floor,
  input  logic        pipe_passed,
  output logic [1:0]  state,
  output logic        physics_en,
  output logic        scroll_en,
  output logic        flap_out,
  output logic        world_reset,
  output logic [11:0] score_bcd,
  output logic [11:0] best_bcd,
  output logic        new_best
);

  game_state_t state_q;
  logic [7:0]  frame_cnt;
  logic        flap_pending;
  logic        hit_latched;
  logic        flap_any;
  logic        hit_any;
  logic        score_clear;
  logic        score_inc;

  // Same-cycle requests count toward the frame being closed by frame_tick.
  assign flap_any    = flap_pending | flap_req;
  assign hit_any     = hit_latched | hit;
  assign score_inc   = (state_q == PLAY) && pipe_passed;
  assign score_clear = frame_tick && (state_q == IDLE) && flap_any;
  assign state       = state_q;

  bcd_counter3 #(
    .MAX(to_bcd3(SCORE_MAX))
  ) u_score (
    .clk  (clk),
    .reset(reset),
    .clear(score_clear),
    .inc  (score_inc),
    .count(score_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_cnt    <= '0;
      flap_pending <= 1'b0;
      hit_latched  <= 1'b0;
      physics_en   <= 1'b0;
      scroll_en    <= 1'b0;
      flap_out     <= 1'b0;
      world_reset  <= 1'b0;
      best_bcd     <= '0;
      new_best     <= 1'b0;
    end else begin
      flap_out    <= 1'b0;
      world_reset <= 1'b0;
      if (frame_tick) begin
        flap_pending <= 1'b0;
        hit_latched  <= 1'b0;
      end else begin
        if (flap_req) flap_pending <= 1'b1;
        if (hit)      hit_latched  <= 1'b1;
      end
      if (frame_tick) begin
        case (state_q)
          IDLE: begin
            if (flap_any) begin
              state_q     <= PLAY;
              physics_en  <= 1'b1;
              scroll_en   <= 1'b1;
              world_reset <= 1'b1;
              flap_out    <= 1'b1;
              new_best    <= 1'b0;
              frame_cnt   <= '0;
            end
          end
          PLAY: begin
            if (hit_any || bird_at_floor) begin
              state_q   <= DYING;
              scroll_en <= 1'b0;
              frame_cnt <= '0;
            end else if (flap_any) begin
              flap_out <= 1'b1;
            end
          end
          DYING: begin
            if (bird_at_floor || (frame_cnt == 8'(DIE_FRAMES - 1))) begin
              state_q    <= OVER;
              physics_en <= 1'b0;
              frame_cnt  <= '0;
              if (bcd3_gt(score_bcd, best_bcd)) begin
                best_bcd <= score_bcd;
                new_best <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          OVER: begin
            if (frame_cnt < 8'(OVER_HOLD)) begin
              frame_cnt <= frame_cnt + 8'd1;
            end else if (flap_any) begin
              state_q     <= IDLE;
              world_reset <= 1'b1;
              frame_cnt   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
